processor_datapath: RTL and testbench
=====================================

PROCESSOR_DATAPATH -- requirements
Module: processor_datapath

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; all other ports are listed below.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- PC_clr  in  1  clear program counter
- PC_up  in  1  increment program counter
- PC  out  8  program counter / instruction memory address
- I_data  in  16  instruction word from external instruction memory at address PC
- IR_ld  in  1  load instruction register from I_data
- IR  out  16  instruction register, returned to controller
- D_addr  in  8  data memory address
- D_wr  in  1  data memory write enable
- RF_s  in  1  register file write mux: 0 = ALU result, 1 = data memory read data
- RF_W_addr  in  4  register file write address
- RF_W_en  in  1  register file write enable
- RF_Ra_addr  in  4  register file read port A address
- RF_Rb_addr  in  4  register file read port B address
- ALU_s0  in  3  ALU operation select
- Ra_data  out  16  register file port A read data (debug/observe)
- Rb_data  out  16  register file port B read data (debug/observe)
- ALU_out  out  16  combinational ALU result
- ALU_Z  out  1  registered zero flag

Function
REQ-002 PC SHALL be an 8-bit register.
- PC_clr=1: PC becomes 0, overriding PC_up.
- PC_up=1 alone: PC increments by 1, wrapping 255->0.
- Otherwise PC holds.
REQ-003 IR SHALL load I_data on a clock edge with IR_ld=1 and SHALL hold otherwise.
REQ-004 The register file SHALL have 16 entries of 16 bits, two asynchronous read ports (A, B) and one synchronous write port.
REQ-005 A register write SHALL occur on an edge with RF_W_en=1.
- Data: ALU_out when RF_s=0; data memory read data when RF_s=1.
REQ-006 The register file SHALL NOT bypass writes: a read of the register being written returns the old value until after the edge.
REQ-007 Data memory SHALL have 256 entries of 16 bits.
- Read: asynchronous from D_addr.
- Write: Ra_data written to D_addr on an edge with D_wr=1.
- A simultaneous read of the same address returns the pre-edge value.
REQ-008 ALU_out SHALL be computed combinationally, modulo 2^16, from A=Ra_data and B=Rb_data:
- 0: A
- 1: A+B
- 2: A-B
- 3: A&B
- 4: A|B
- 5: A^B
- 6: ~A
- 7: 0
REQ-009 ALU_Z SHALL register (ALU_out==0) on any edge with RF_W_en=1 and RF_s=0, and SHALL hold otherwise.
REQ-010 D_wr=1 together with RF_W_en=1 and RF_s=1 in the same cycle SHALL write memory and load the register with the pre-edge memory contents.
REQ-011 Unused combinations (for example, RF_s=1 with RF_W_en=0) SHALL have no side effects.

Reset
REQ-012 While reset=0, the block SHALL asynchronously force PC=0, IR=0, all 16 registers=0 and ALU_Z=0, and SHALL ignore every control input.
REQ-013 Data memory contents SHALL NOT be affected by reset; they are loadable by simulation init only.
REQ-014 Reset asserted mid-operation SHALL abort any pending write; operation resumes on the first rising edge after reset returns to 1.

Verification
REQ-015 PC scenario: reset, then PC_up=1 for 257 cycles -> PC goes 0,1,...,255,0,1; PC_clr=1 with PC_up=1 -> PC=0 next edge.
REQ-016 Load scenario: data memory preloaded with mem[10]=16'h1234; D_addr=10, RF_s=1, RF_W_addr=7, RF_W_en=1 for one edge -> reg7=16'h1234, ALU_Z unchanged.
REQ-017 Store scenario: reg15=16'h00AB; RF_Ra_addr=15, D_addr=41, D_wr=1 for one edge -> mem[41]=16'h00AB, observed via D_addr=41 the next cycle.
REQ-018 Arithmetic scenario: reg1=5, reg2=5.
- ALU_s0=1, write to reg3 -> reg3=10, ALU_Z=0.
- ALU_s0=2, write to reg3 -> reg3=0, ALU_Z=1.
- reg1=0, reg2=1, ALU_s0=2 -> 16'hFFFF.
REQ-019 No-bypass scenario: RF_W_addr=RF_Ra_addr=3 with RF_W_en=1 in the same cycle -> Ra_data shows the old value until the edge, the new value after it.
REQ-020 Reset scenario: assert reset between clock edges mid-sequence -> PC, IR, registers and ALU_Z go to 0 immediately without waiting for a clock edge; data memory is retained.

Source files
------------

// File: rtl/processor_datapath.sv
// Single-cycle processor datapath: PC, instruction register, 16x16 register file,
// 256x16 data memory and an 8-function ALU with a registered zero flag.
module processor_datapath #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8,
    parameter int RF_AW  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PC_clr,
    input  logic              PC_up,
    output logic [PC_W-1:0]   PC,
    input  logic [DATA_W-1:0] I_data,
    input  logic              IR_ld,
    output logic [DATA_W-1:0] IR,
    input  logic [7:0]        D_addr,
    input  logic              D_wr,
    input  logic              RF_s,
    input  logic [RF_AW-1:0]  RF_W_addr,
    input  logic              RF_W_en,
    input  logic [RF_AW-1:0]  RF_Ra_addr,
    input  logic [RF_AW-1:0]  RF_Rb_addr,
    input  logic [2:0]        ALU_s0,
    output logic [DATA_W-1:0] Ra_data,
    output logic [DATA_W-1:0] Rb_data,
    output logic [DATA_W-1:0] ALU_out,
    output logic              ALU_Z
);

    localparam int RF_N = 1 << RF_AW;

    logic [DATA_W-1:0] rf   [RF_N];
    logic [DATA_W-1:0] dmem [256];
    logic [DATA_W-1:0] d_rdata;
    logic [DATA_W-1:0] rf_wdata;

    // Two's-complement arithmetic wraps naturally at DATA_W bits.
    function automatic logic [DATA_W-1:0] alu_f(
        input logic [2:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] r;
        case (op)
            3'd0:    r = a;
            3'd1:    r = a + b;
            3'd2:    r = a - b;
            3'd3:    r = a & b;
            3'd4:    r = a | b;
            3'd5:    r = a ^ b;
            3'd6:    r = ~a;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign Ra_data  = rf[RF_Ra_addr];
    assign Rb_data  = rf[RF_Rb_addr];
    assign d_rdata  = dmem[D_addr];
    assign ALU_out  = alu_f(ALU_s0, Ra_data, Rb_data);
    assign rf_wdata = RF_s ? d_rdata : ALU_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC    <= '0;
            IR    <= '0;
            ALU_Z <= 1'b0;
            for (int i = 0; i < RF_N; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (PC_clr) begin
                PC <= '0;
            end else if (PC_up) begin
                PC <= PC + 1'b1;
            end
            if (IR_ld) begin
                IR <= I_data;
            end
            if (RF_W_en) begin
                rf[RF_W_addr] <= rf_wdata;
                if (!RF_s) begin
                    ALU_Z <= (ALU_out == '0);
                end
            end
        end
    end

    // Memory has no reset, but a write is still suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (reset && D_wr) begin
            dmem[D_addr] <= Ra_data;
        end
    end

endmodule

// File: tb/tb_processor_datapath.sv
// Bench for processor_datapath: directed tables and sequences plus random cycles
// checked against an array-based behavioural model.
module tb_processor_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
    logic [7:0]  PC, D_addr;
    logic [15:0] I_data, IR, Ra_data, Rb_data, ALU_out;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic        ALU_Z;

    always #5 clk = ~clk;

    processor_datapath dut (
        .clk(clk), .reset(reset), .PC_clr(PC_clr), .PC_up(PC_up), .PC(PC),
        .I_data(I_data), .IR_ld(IR_ld), .IR(IR), .D_addr(D_addr), .D_wr(D_wr),
        .RF_s(RF_s), .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .ALU_s0(ALU_s0),
        .Ra_data(Ra_data), .Rb_data(Rb_data), .ALU_out(ALU_out), .ALU_Z(ALU_Z)
    );

    typedef struct {
        logic        pc_clr, pc_up, ir_ld;
        logic [15:0] i_data;
        logic [7:0]  d_addr;
        logic        d_wr, rf_s;
        logic [3:0]  w_addr;
        logic        w_en;
        logic [3:0]  ra, rb;
        logic [2:0]  op;
    } ctl_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a, b, res;
        logic        z;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    logic [15:0] m_rf [16];
    logic [15:0] m_mem [256];
    bit          m_ok [256];
    logic        m_z;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0: return a;
            3'd1: return a + b;
            3'd2: return a - b;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a ^ b;
            3'd6: return ~a;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_reset();
        m_pc = 8'h00;
        m_ir = 16'h0000;
        m_z  = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
    endtask

    function automatic ctl_t idle();
        ctl_t c;
        c.pc_clr = 0; c.pc_up = 0; c.ir_ld = 0; c.i_data = 16'h0000;
        c.d_addr = 8'h00; c.d_wr = 0; c.rf_s = 0; c.w_addr = 4'h0;
        c.w_en = 0; c.ra = 4'h0; c.rb = 4'h0; c.op = 3'd0;
        return c;
    endfunction

    task automatic drive(input ctl_t c);
        PC_clr = c.pc_clr; PC_up = c.pc_up; IR_ld = c.ir_ld; I_data = c.i_data;
        D_addr = c.d_addr; D_wr = c.d_wr; RF_s = c.rf_s; RF_W_addr = c.w_addr;
        RF_W_en = c.w_en; RF_Ra_addr = c.ra; RF_Rb_addr = c.rb; ALU_s0 = c.op;
    endtask

    // One clock cycle starting from a falling edge; model updated with pre-edge values.
    task automatic cycle(input ctl_t c);
        logic [15:0] a, res, rd;
        drive(c);
        #1;
        a   = m_rf[c.ra];
        res = ref_alu(c.op, a, m_rf[c.rb]);
        rd  = m_mem[c.d_addr];
        chk("ra_data", Ra_data, a);
        chk("rb_data", Rb_data, m_rf[c.rb]);
        chk("alu_out", ALU_out, res);
        @(posedge clk);
        #1;
        if (c.pc_clr) m_pc = 8'h00;
        else if (c.pc_up) m_pc = m_pc + 8'h01;
        if (c.ir_ld) m_ir = c.i_data;
        if (c.w_en) begin
            m_rf[c.w_addr] = c.rf_s ? rd : res;
            if (!c.rf_s) m_z = (res == 16'h0000);
        end
        if (c.d_wr) begin
            m_mem[c.d_addr] = a;
            m_ok[c.d_addr]  = 1'b1;
        end
        chk("pc", {8'h00, PC}, {8'h00, m_pc});
        chk("ir", IR, m_ir);
        chk("alu_z", {15'h0, ALU_Z}, {15'h0, m_z});
        @(negedge clk);
    endtask

    task automatic alu_wr(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] w);
        ctl_t c = idle();
        c.op = op; c.ra = ra; c.rb = rb; c.w_addr = w; c.w_en = 1'b1;
        cycle(c);
    endtask

    // Builds an arbitrary constant from nothing: r12 = 1, then shift-and-add. Target not 12..14.
    task automatic set_reg(input logic [3:0] r, input logic [15:0] v);
        alu_wr(3'd7, 4'd0, 4'd0, 4'd13);
        alu_wr(3'd6, 4'd13, 4'd0, 4'd14);
        alu_wr(3'd2, 4'd13, 4'd14, 4'd12);
        alu_wr(3'd7, 4'd0, 4'd0, r);
        for (int i = 15; i >= 0; i--) begin
            alu_wr(3'd1, r, r, r);
            if (v[i]) alu_wr(3'd1, r, 4'd12, r);
        end
    endtask

    task automatic store(input logic [3:0] r, input logic [7:0] addr);
        ctl_t c = idle();
        c.ra = r; c.d_addr = addr; c.d_wr = 1'b1;
        cycle(c);
    endtask

    task automatic load(input logic [7:0] addr, input logic [3:0] w);
        ctl_t c = idle();
        c.d_addr = addr; c.rf_s = 1'b1; c.w_addr = w; c.w_en = 1'b1;
        cycle(c);
    endtask

    task automatic peek(input string name, input logic [3:0] r, input logic [15:0] exp);
        ctl_t c = idle();
        c.ra = r;
        drive(c);
        #1;
        chk(name, Ra_data, exp);
        @(negedge clk);
    endtask

    vec_t tab[11];

    initial begin
        ctl_t c;
        tab = '{
            '{3'd1, 16'h0005, 16'h0005, 16'h000A, 1'b0},
            '{3'd2, 16'h0005, 16'h0005, 16'h0000, 1'b1},
            '{3'd2, 16'h0000, 16'h0001, 16'hFFFF, 1'b0},
            '{3'd0, 16'h1234, 16'h5678, 16'h1234, 1'b0},
            '{3'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1},
            '{3'd1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0},
            '{3'd3, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0},
            '{3'd4, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0},
            '{3'd5, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0},
            '{3'd6, 16'h00FF, 16'h1234, 16'hFF00, 1'b0},
            '{3'd7, 16'h1234, 16'h5678, 16'h0000, 1'b1}
        };
        for (int i = 0; i < 256; i++) begin
            m_mem[i] = 16'h0000;
            m_ok[i]  = 1'b0;
        end

        // Power-on reset
        reset = 1'b0;
        drive(idle());
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", {8'h00, PC}, 16'h0000);
        chk("rst_ir", IR, 16'h0000);
        chk("rst_z", {15'h0, ALU_Z}, 16'h0000);
        reset = 1'b1;
        m_reset();
        for (int r = 0; r < 16; r++) peek("rst_reg", 4'(r), 16'h0000);

        // PC: 257 increments, then clear beats increment
        for (int k = 0; k < 257; k++) begin
            c = idle(); c.pc_up = 1'b1;
            cycle(c);
            chk("pc_seq", {8'h00, PC}, 16'((k + 1) % 256));
        end
        c = idle(); c.pc_clr = 1'b1; c.pc_up = 1'b1;
        cycle(c);
        chk("pc_clr", {8'h00, PC}, 16'h0000);

        // IR load and hold
        c = idle(); c.ir_ld = 1'b1; c.i_data = 16'hA5C3;
        cycle(c);
        chk("ir_load", IR, 16'hA5C3);
        c = idle(); c.i_data = 16'hFFFF;
        cycle(c);
        chk("ir_hold", IR, 16'hA5C3);

        // ALU table, writing each result to reg3
        foreach (tab[i]) begin
            set_reg(4'd1, tab[i].a);
            set_reg(4'd2, tab[i].b);
            c = idle(); c.op = tab[i].op; c.ra = 4'd1; c.rb = 4'd2; c.w_addr = 4'd3; c.w_en = 1'b1;
            drive(c);
            #1;
            chk("alu_tab", ALU_out, tab[i].res);
            cycle(c);
            chk("alu_tab_z", {15'h0, ALU_Z}, {15'h0, tab[i].z});
            peek("alu_tab_wr", 4'd3, tab[i].res);
        end

        // Load leaves ALU_Z alone
        set_reg(4'd5, 16'h1234);
        store(4'd5, 8'd10);
        alu_wr(3'd7, 4'd0, 4'd0, 4'd6);
        load(8'd10, 4'd7);
        chk("load_z", {15'h0, ALU_Z}, 16'h0001);
        peek("load_reg7", 4'd7, 16'h1234);

        // Store then read back
        set_reg(4'd15, 16'h00AB);
        store(4'd15, 8'd41);
        load(8'd41, 4'd8);
        peek("store_mem41", 4'd8, 16'h00AB);

        // Simultaneous store and load at one address sees pre-edge memory
        set_reg(4'd4, 16'hBEEF);
        store(4'd4, 8'd20);
        set_reg(4'd4, 16'h1111);
        c = idle(); c.ra = 4'd4; c.d_addr = 8'd20; c.d_wr = 1'b1; c.rf_s = 1'b1; c.w_addr = 4'd9; c.w_en = 1'b1;
        cycle(c);
        peek("ldst_old", 4'd9, 16'hBEEF);
        load(8'd20, 4'd10);
        peek("ldst_new", 4'd10, 16'h1111);

        // RF_s without write enable does nothing
        c = idle(); c.rf_s = 1'b1; c.d_addr = 8'd41; c.w_addr = 4'd9;
        cycle(c);
        peek("unused_combo", 4'd9, 16'hBEEF);

        // No bypass on same-cycle read of the written register
        set_reg(4'd3, 16'h0F0F);
        c = idle(); c.op = 3'd6; c.ra = 4'd3; c.w_addr = 4'd3; c.w_en = 1'b1;
        drive(c);
        #1;
        chk("nobyp_old", Ra_data, 16'h0F0F);
        cycle(c);
        chk("nobyp_new", Ra_data, 16'hF0F0);

        // Asynchronous reset mid-sequence with writes pending
        c = idle(); c.pc_up = 1'b1; c.ir_ld = 1'b1; c.i_data = 16'h4321;
        cycle(c);
        c = idle(); c.pc_up = 1'b1; c.ir_ld = 1'b1; c.i_data = 16'h9999; c.op = 3'd6;
        c.ra = 4'd1; c.w_addr = 4'd3; c.w_en = 1'b1; c.d_wr = 1'b1; c.d_addr = 8'd41;
        drive(c);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_pc", {8'h00, PC}, 16'h0000);
        chk("arst_ir", IR, 16'h0000);
        chk("arst_z", {15'h0, ALU_Z}, 16'h0000);
        @(posedge clk);
        #1;
        chk("arst_hold_pc", {8'h00, PC}, 16'h0000);
        chk("arst_hold_ir", IR, 16'h0000);
        @(negedge clk);
        for (int r = 0; r < 16; r++) peek("arst_reg", 4'(r), 16'h0000);
        reset = 1'b1;
        m_reset();
        load(8'd41, 4'd8);
        peek("arst_mem_kept", 4'd8, 16'h00AB);
        c = idle(); c.pc_up = 1'b1;
        cycle(c);
        chk("arst_resume", {8'h00, PC}, 16'h0001);

        // Random traffic against the model
        for (int r = 1; r < 12; r++) set_reg(4'(r), 16'($urandom));
        for (int a = 0; a < 16; a++) store(4'(a), 8'(a));
        for (int n = 0; n < 800; n++) begin
            c.pc_clr = ($urandom_range(0, 15) == 0);
            c.pc_up  = 1'($urandom);
            c.ir_ld  = 1'($urandom);
            c.i_data = 16'($urandom);
            c.d_addr = 8'($urandom_range(0, 15));
            c.d_wr   = ($urandom_range(0, 3) == 0);
            c.rf_s   = 1'($urandom);
            c.w_addr = 4'($urandom);
            c.w_en   = 1'($urandom);
            c.ra     = 4'($urandom);
            c.rb     = 4'($urandom);
            c.op     = 3'($urandom);
            if (!m_ok[c.d_addr]) c.rf_s = 1'b0;
            cycle(c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
